// File: rtl/pipelined_csel_adder_if.sv
// Operand/result bus for pipelined_csel_adder.
// master: the producer of operands and consumer of results; slave: the adder.
interface pipelined_csel_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select add/subtract unit.
// The WIDTH-bit carry chain is cut into STAGES segments of S = WIDTH/STAGES bits,
// one segment resolved per stage. WIDTH must be a multiple of STAGES.
// Optional build macro: CSA_OVF_FLAG_EN -- registers a signed-overflow flag on ovf;
// without it ovf is tied low.
//
// Handshake (both sides): a beat transfers on a rising edge where valid && ready.
// The whole pipe moves together: advance = !out_valid | out_ready, and
// in_ready = advance (forced high while rst_n=0). in_valid never affects in_ready.
// When advance=0 every stage register, valid bits included, holds its value.
module pipelined_csel_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipelined_csel_adder_if.slave bus
);

  localparam int S = WIDTH / STAGES;

  // Per-stage registers. Operand words shift down by S each stage so the
  // segment a stage works on is always in bits [S-1:0]; the finished sum bits
  // shift in from the top, so after STAGES stages s_r holds the full result.
  logic [STAGES-1:0] vld_r;
  logic [STAGES-1:0] c_r;
  logic [WIDTH-1:0]  a_r [STAGES];
  logic [WIDTH-1:0]  b_r [STAGES];
  logic [WIDTH-1:0]  s_r [STAGES];

  // Stage sources and next values.
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  nxt_a [STAGES];
  logic [WIDTH-1:0]  nxt_b [STAGES];
  logic [WIDTH-1:0]  nxt_s [STAGES];
  logic [STAGES-1:0] nxt_c;
  logic              last_sum_msb;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign advance      = !vld_r[STAGES-1] || bus.out_ready;
  assign bus.in_ready = advance || !rst_n;

  // Subtraction is a + ~b + ~cin, so the borrow-in becomes an inverted carry-in.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.cin ^ bus.sub;

  // Stage k takes its operands from stage k-1 (stage 0 from the bus).
  always_comb begin
    src_a[0] = bus.a;
    src_b[0] = b_eff;
    src_s[0] = '0;
    src_c[0] = c_eff;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_r[k-1];
      src_b[k] = b_r[k-1];
      src_s[k] = s_r[k-1];
      src_c[k] = c_r[k-1];
    end
  end

  // Carry-select segment: both carry-in candidates are formed, then the
  // registered carry from the previous stage picks one.
  always_comb begin
    logic [S:0] cand0;
    logic [S:0] cand1;
    logic [S:0] seg;
    cand0        = '0;
    cand1        = '0;
    seg          = '0;
    last_sum_msb = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      cand0    = {1'b0, src_a[k][S-1:0]} + {1'b0, src_b[k][S-1:0]};
      cand1    = cand0 + (S+1)'(1);
      seg      = src_c[k] ? cand1 : cand0;
      nxt_c[k] = seg[S];
      nxt_a[k] = src_a[k] >> S;
      nxt_b[k] = src_b[k] >> S;
      nxt_s[k] = (src_s[k] >> S) | (WIDTH'(seg[S-1:0]) << (WIDTH - S));
      if (k == STAGES - 1) begin
        last_sum_msb = seg[S-1];
      end
    end
  end

  // Pipeline registers: reset clears everything, otherwise all stages move on advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r <= '0;
      c_r   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
      end
    end else if (advance) begin
      vld_r[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_r[k] <= vld_r[k-1];
      end
      c_r <= nxt_c;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= nxt_a[k];
        b_r[k] <= nxt_b[k];
        s_r[k] <= nxt_s[k];
      end
    end
  end

  assign bus.out_valid = vld_r[STAGES-1];
  assign bus.sum       = s_r[STAGES-1];
  assign bus.cout      = c_r[STAGES-1];

`ifdef CSA_OVF_FLAG_EN
  // The top operand segment reaches the last stage in bits [S-1:0] of the
  // skewed operand words, so the operand MSBs are bit S-1 there.
  logic ovf_r;
  logic ovf_nx;

  assign ovf_nx = (src_a[STAGES-1][S-1] == src_b[STAGES-1][S-1]) &&
                  (last_sum_msb != src_a[STAGES-1][S-1]);

  // Overflow flag registered alongside the final sum segment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (advance) begin
      ovf_r <= ovf_nx;
    end
  end

  assign bus.ovf = ovf_r;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule
